// File: rtl/vote_capture.sv
// vote_capture: ballot-side front end of the EVM.
// Each raw candidate button is synchronized and debounced. In voting mode,
// exactly one fresh press while IDLE counts one vote. A lockout window and a
// wait-for-release state then stop a held or bouncing button from voting twice.
module vote_capture #(
  parameter int COUNT_WIDTH     = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   button1,
  input  logic                   button2,
  input  logic                   button3,
  input  logic                   button4,
  output logic                   candidate1_button_press,
  output logic                   candidate2_button_press,
  output logic                   candidate3_button_press,
  output logic                   candidate4_button_press,
  output logic [COUNT_WIDTH-1:0] candidate1_votes,
  output logic [COUNT_WIDTH-1:0] candidate2_votes,
  output logic [COUNT_WIDTH-1:0] candidate3_votes,
  output logic [COUNT_WIDTH-1:0] candidate4_votes,
  output logic                   valid_vote_casted,
  output logic                   vote_rejected,
  output logic                   overflow,
  output logic                   busy
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LCW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] TALLY_MAX = '1;
  localparam logic [DCW-1:0]         DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCW-1:0]         LOCK_LOAD = LCW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    LOCKOUT,
    WAIT_RELEASE
  } state_t;

  state_t                 state;
  logic [3:0]             raw;
  logic [3:0]             sync_q1;
  logic [3:0]             sync_q2;
  logic [3:0]             level;
  logic [3:0]             level_d;
  logic [3:0]             press_evt;
  logic [3:0]             saturated;
  logic                   multi_press;
  logic [DCW-1:0]         db_cnt [4];
  logic [COUNT_WIDTH-1:0] tally  [4];
  logic [LCW-1:0]         lock_cnt;

  assign raw = {button4, button3, button2, button1};

  // Two-flop synchronizer for the asynchronous buttons.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      level_d <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync_q2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // level and level_d are both flops, so press_evt is a clean one-cycle pulse;
  // the FSM consumes it on the edge DEBOUNCE_CYCLES+3 after the raw press.
  assign press_evt   = level & ~level_d;
  assign multi_press = |(press_evt & (press_evt - 4'd1));

  // Per-candidate saturation flags used to refuse a vote instead of wrapping.
  // NOTE: combinational blocks assign a default before any branch so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    saturated = '0;
    for (int i = 0; i < 4; i++) saturated[i] = (tally[i] == TALLY_MAX);
  end

  // Vote FSM: accepts, refuses or ignores presses and owns tallies and pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      lock_cnt          <= '0;
      valid_vote_casted <= 1'b0;
      vote_rejected     <= 1'b0;
      overflow          <= 1'b0;
      busy              <= 1'b0;
      // NOTE: the tallies are four small registers rather than a RAM, so they
      // are cleared by reset like any other state; a pending vote is discarded.
      for (int i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      valid_vote_casted <= 1'b0;
      vote_rejected     <= 1'b0;
      case (state)
        IDLE: begin
          if (!mode && (press_evt != '0)) begin
            busy <= 1'b1;
            if (multi_press) begin
              vote_rejected <= 1'b1;
              state         <= WAIT_RELEASE;
            end else if ((press_evt & saturated) != '0) begin
              vote_rejected <= 1'b1;
              overflow      <= 1'b1;
              state         <= WAIT_RELEASE;
            end else begin
              for (int i = 0; i < 4; i++) begin
                if (press_evt[i]) tally[i] <= tally[i] + 1'b1;
              end
              valid_vote_casted <= 1'b1;
              lock_cnt          <= LOCK_LOAD;
              state             <= LOCKOUT;
            end
          end
        end
        LOCKOUT: begin
          if (lock_cnt <= LCW'(1)) begin
            lock_cnt <= '0;
            state    <= WAIT_RELEASE;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (level == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign candidate1_button_press = level[0];
  assign candidate2_button_press = level[1];
  assign candidate3_button_press = level[2];
  assign candidate4_button_press = level[3];
  assign candidate1_votes        = tally[0];
  assign candidate2_votes        = tally[1];
  assign candidate3_votes        = tally[2];
  assign candidate4_votes        = tally[3];

endmodule

// File: tb/tb_vote_capture.sv
// Testbench for vote_capture: directed scenarios plus randomized button
// activity, all checked every cycle against a behavioural model.
module tb_vote_capture;

  localparam int CW   = 4;
  localparam int DB   = 4;
  localparam int LK   = 10;
  localparam int TMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mode = 1'b0;
  logic          button1 = 1'b0;
  logic          button2 = 1'b0;
  logic          button3 = 1'b0;
  logic          button4 = 1'b0;
  logic          candidate1_button_press;
  logic          candidate2_button_press;
  logic          candidate3_button_press;
  logic          candidate4_button_press;
  logic [CW-1:0] candidate1_votes;
  logic [CW-1:0] candidate2_votes;
  logic [CW-1:0] candidate3_votes;
  logic [CW-1:0] candidate4_votes;
  logic          valid_vote_casted;
  logic          vote_rejected;
  logic          overflow;
  logic          busy;

  vote_capture #(
    .COUNT_WIDTH    (CW),
    .DEBOUNCE_CYCLES(DB),
    .LOCKOUT_CYCLES (LK)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .mode                   (mode),
    .button1                (button1),
    .button2                (button2),
    .button3                (button3),
    .button4                (button4),
    .candidate1_button_press(candidate1_button_press),
    .candidate2_button_press(candidate2_button_press),
    .candidate3_button_press(candidate3_button_press),
    .candidate4_button_press(candidate4_button_press),
    .candidate1_votes       (candidate1_votes),
    .candidate2_votes       (candidate2_votes),
    .candidate3_votes       (candidate3_votes),
    .candidate4_votes       (candidate4_votes),
    .valid_vote_casted      (valid_vote_casted),
    .vote_rejected          (vote_rejected),
    .overflow               (overflow),
    .busy                   (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model, advanced once per clock edge.
  logic [3:0] raw_hist [$];   // raw button value present at each edge
  logic [3:0] m_level;        // debounced levels after the latest edge
  logic [3:0] m_level_prev;   // debounced levels one edge earlier
  int         m_tally [4];
  bit         m_ovf;
  bit         m_hold;         // a vote or refusal happened; waiting for all buttons up
  int         m_cycle;
  int         m_lock_end;     // last edge of the post-vote lockout window
  bit         m_valid;
  bit         m_rej;
  int         valid_cnt = 0;
  int         rej_cnt   = 0;

  function automatic void model_reset();
    raw_hist.delete();
    for (int j = 0; j < DB + 2; j++) raw_hist.push_back(4'b0000);
    m_level      = '0;
    m_level_prev = '0;
    for (int i = 0; i < 4; i++) m_tally[i] = 0;
    m_ovf      = 0;
    m_hold     = 0;
    m_cycle    = 0;
    m_lock_end = 0;
    m_valid    = 0;
    m_rej      = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] raw, input logic md);
    logic [3:0] p;
    logic [3:0] lvl_new;
    logic [3:0] sample;
    bit         all_diff;
    m_cycle++;
    raw_hist.push_back(raw);
    void'(raw_hist.pop_front());
    p       = m_level & ~m_level_prev;
    m_valid = 0;
    m_rej   = 0;
    if (m_hold) begin
      if (m_cycle > m_lock_end && m_level == 4'b0000) m_hold = 0;
    end else if (!md && p != 4'b0000) begin
      m_hold = 1;
      if ($countones(p) > 1) begin
        m_rej = 1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (p[i]) begin
            if (m_tally[i] == TMAX) begin
              m_rej = 1;
              m_ovf = 1;
            end else begin
              m_tally[i]++;
              m_valid    = 1;
              m_lock_end = m_cycle + LK;
            end
          end
        end
      end
    end
    // A debounced level flips once the last DB synchronized samples
    // (raw delayed by two edges) all disagree with it.
    lvl_new = m_level;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1;
      for (int j = 0; j < DB; j++) begin
        sample = raw_hist[raw_hist.size() - 3 - j];
        if (sample[i] == m_level[i]) all_diff = 0;
      end
      if (all_diff) lvl_new[i] = ~m_level[i];
    end
    m_level_prev = m_level;
    m_level      = lvl_new;
  endfunction

  function automatic logic [31:0] dut_vec();
    return {8'h00,
            candidate4_button_press, candidate3_button_press,
            candidate2_button_press, candidate1_button_press,
            candidate4_votes, candidate3_votes, candidate2_votes, candidate1_votes,
            valid_vote_casted, vote_rejected, overflow, busy};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {8'h00, m_level,
            CW'(m_tally[3]), CW'(m_tally[2]), CW'(m_tally[1]), CW'(m_tally[0]),
            m_valid, m_rej, m_ovf, m_hold};
  endfunction

  // Called at a negedge: drive inputs, advance one posedge, compare, return at next negedge.
  task automatic cycle(input logic [3:0] b, input logic md);
    {button4, button3, button2, button1} = b;
    mode = md;
    @(posedge clock);
    model_edge(b, md);
    #1;
    check("outputs", dut_vec(), exp_vec());
    if (valid_vote_casted) valid_cnt++;
    if (vote_rejected) rej_cnt++;
    @(negedge clock);
  endtask

  // Called at a negedge: assert reset, check the immediate clear, release at a later negedge.
  task automatic apply_reset(input logic [3:0] b_during);
    reset = 1'b0;
    {button4, button3, button2, button1} = b_during;
    #1;
    check("reset_outputs", dut_vec(), 32'h0);
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] b;
    logic       md;
    logic       pmax;
    int         len;
    int         first;
    int         v0;
    int         r0;

    model_reset();
    repeat (2) @(negedge clock);
    check("reset_state", dut_vec(), 32'h0);
    reset = 1'b1;
    repeat (3) cycle(4'b0000, 1'b0);

    // 1: single held press on button2.
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      cycle(4'b0010, 1'b0);
      if (valid_vote_casted && first < 0) first = n;
      if (n == 17) check("t1_busy_in_lockout", 32'(busy), 32'd1);
    end
    check("t1_latency", 32'(first), 32'd7);
    repeat (15) cycle(4'b0000, 1'b0);
    check("t1_votes2", 32'(candidate2_votes), 32'd1);
    check("t1_votes_other", 32'({candidate4_votes, candidate3_votes, candidate1_votes}), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: short glitches on button1.
    v0   = valid_cnt;
    pmax = 1'b0;
    cycle(4'b0001, 1'b0);
    if (candidate1_button_press) pmax = 1'b1;
    cycle(4'b0000, 1'b0);
    if (candidate1_button_press) pmax = 1'b1;
    cycle(4'b0001, 1'b0);
    if (candidate1_button_press) pmax = 1'b1;
    for (int n = 0; n < 12; n++) begin
      cycle(4'b0000, 1'b0);
      if (candidate1_button_press) pmax = 1'b1;
    end
    check("t2_no_level", 32'(pmax), 32'd0);
    check("t2_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t2_votes1", 32'(candidate1_votes), 32'd0);

    // 3: two buttons at once.
    v0 = valid_cnt;
    r0 = rej_cnt;
    repeat (12) cycle(4'b1100, 1'b0);
    check("t3_rejected", 32'(rej_cnt - r0), 32'd1);
    check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t3_busy_held", 32'(busy), 32'd1);
    repeat (10) cycle(4'b1000, 1'b0);
    check("t3_busy_partial", 32'(busy), 32'd1);
    repeat (10) cycle(4'b0000, 1'b0);
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_votes34", 32'({candidate4_votes, candidate3_votes}), 32'd0);

    // 4: saturation of candidate 1.
    apply_reset(4'b0000);
    for (int v = 1; v <= 16; v++) begin
      v0 = valid_cnt;
      r0 = rej_cnt;
      repeat (10) cycle(4'b0001, 1'b0);
      repeat (20) cycle(4'b0000, 1'b0);
      if (v == 15) check("t4_votes15", 32'(candidate1_votes), 32'd15);
      if (v == 16) begin
        check("t4_rejected", 32'(rej_cnt - r0), 32'd1);
        check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_votes_held", 32'(candidate1_votes), 32'd15);
      end
    end

    // 5: result mode ignores presses, voting mode counts them.
    v0 = valid_cnt;
    for (int n = 1; n <= 10; n++) begin
      cycle(4'b0010, 1'b1);
      if (n == 9) check("t5_level_in_result", 32'(candidate2_button_press), 32'd1);
    end
    repeat (10) cycle(4'b0000, 1'b1);
    check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t5_votes2_same", 32'(candidate2_votes), 32'd0);
    repeat (10) cycle(4'b0010, 1'b0);
    repeat (20) cycle(4'b0000, 1'b0);
    check("t5_counted", 32'(valid_cnt - v0), 32'd1);
    check("t5_votes2", 32'(candidate2_votes), 32'd1);

    // 6: reset in the middle of a lockout.
    repeat (10) cycle(4'b0001, 1'b0);
    apply_reset(4'b0001);
    repeat (10) cycle(4'b0000, 1'b0);
    repeat (10) cycle(4'b0001, 1'b0);
    repeat (20) cycle(4'b0000, 1'b0);
    check("t6_recount", 32'(candidate1_votes), 32'd1);
    check("t6_idle", 32'(busy), 32'd0);

    // Randomized activity: held patterns with bounce, mode flips and resets.
    for (int seg = 0; seg < 250; seg++) begin
      len = $urandom_range(0, 19);
      if (len < 10)      pat = 4'b0000;
      else if (len < 17) pat = 4'(1 << $urandom_range(0, 3));
      else               pat = 4'($urandom);
      md  = ($urandom_range(0, 7) == 0);
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 39) == 0) apply_reset(pat);
      for (int c = 0; c < len; c++) begin
        b = pat;
        if ($urandom_range(0, 5) == 0) b = b ^ 4'($urandom);
        cycle(b, md);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
